// File: rtl/pulse_generator.sv
`timescale 1ns/1ps
// Strobe-to-pulse converter: a programmable delay followed by a programmable-length level pulse,
// with busy/done status and a saturating count of strobes that could not be accepted.
module pulse_generator #(
    parameter int COUNT_WIDTH = 8,
    parameter int DROP_WIDTH  = 8
) (
    input  logic                   in_clock,
    input  logic                   in_reset_n,
    input  logic                   in_strobe,
    input  logic [COUNT_WIDTH-1:0] in_delay,
    input  logic [COUNT_WIDTH-1:0] in_length,
    input  logic                   in_retrigger,
    output logic                   out_signal,
    output logic                   out_busy,
    output logic                   out_done,
    output logic [DROP_WIDTH-1:0]  out_dropped
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
    localparam logic [DROP_WIDTH-1:0]  DROP_ONE  = DROP_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [COUNT_WIDTH-1:0]  length_q, length_d;
    logic [DROP_WIDTH-1:0]   drops_q, drops_d;
    logic                    end_q, end_d;
    logic                    signal_q, signal_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DROP_WIDTH-1:0]   dropped_q, dropped_d;
    logic                    reject;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        length_d = length_q;
        end_d    = 1'b0;
        reject   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A zero-length request is silently ignored, not counted as dropped.
                if (in_strobe && (in_length != '0)) begin
                    if (in_delay == '0) begin
                        state_d = ST_ACTIVE;
                        count_d = in_length;
                    end else begin
                        state_d  = ST_DELAY;
                        count_d  = in_delay;
                        length_d = in_length;
                    end
                end
            end
            ST_DELAY: begin
                reject = in_strobe;
                if (count_q == COUNT_ONE) begin
                    state_d = ST_ACTIVE;
                    count_d = length_q;
                end else begin
                    count_d = count_q - COUNT_ONE;
                end
            end
            ST_ACTIVE: begin
                // A retrigger beats the natural end of the count, even on its last cycle.
                if (in_strobe && in_retrigger) begin
                    count_d = (in_length == '0) ? COUNT_ONE : in_length;
                end else begin
                    reject = in_strobe;
                    if (count_q == COUNT_ONE) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                        end_d   = 1'b1;
                    end else begin
                        count_d = count_q - COUNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        drops_d = (reject && (drops_q != '1)) ? (drops_q + DROP_ONE) : drops_q;

        // Outputs are a registered image of the control state, one edge behind it.
        signal_d  = (state_q == ST_ACTIVE);
        busy_d    = (state_q != ST_IDLE);
        done_d    = end_q;
        dropped_d = drops_q;
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            length_q  <= '0;
            drops_q   <= '0;
            end_q     <= 1'b0;
            signal_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            length_q  <= length_d;
            drops_q   <= drops_d;
            end_q     <= end_d;
            signal_q  <= signal_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dropped_q <= dropped_d;
        end
    end

    assign out_signal  = signal_q;
    assign out_busy    = busy_q;
    assign out_done    = done_q;
    assign out_dropped = dropped_q;

endmodule

// File: tb/tb_pulse_generator.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for pulse_generator: a request-interval model predicts every
// output cycle, and a monitor compares the DUT against those predictions.
module tb_pulse_generator;

    localparam int CW   = 4;
    localparam int DW   = 2;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          strobe = 1'b0;
    logic [CW-1:0] delay = '0;
    logic [CW-1:0] length = '0;
    logic          retrig = 1'b0;
    logic          out_signal;
    logic          out_busy;
    logic          out_done;
    logic [DW-1:0] out_dropped;

    pulse_generator #(.COUNT_WIDTH(CW), .DROP_WIDTH(DW)) dut (
        .in_clock    (clk),
        .in_reset_n  (rst_n),
        .in_strobe   (strobe),
        .in_delay    (delay),
        .in_length   (length),
        .in_retrigger(retrig),
        .out_signal  (out_signal),
        .out_busy    (out_busy),
        .out_done    (out_done),
        .out_dropped (out_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sig;
        bit busy;
        bit done;
        int drops;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    // Model: the accepted request occupies edges [acc, act_end]; the pulse spans [act_start, act_end].
    int   e_now = 0;
    bit   have = 1'b0;
    int   act_start = 0;
    int   act_end = 0;
    int   drops = 0;
    exp_t prev;

    task automatic chk(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, actual, required);
        end
    endtask

    task automatic model_clear();
        have  = 1'b0;
        drops = 0;
        prev  = '{sig: 1'b0, busy: 1'b0, done: 1'b0, drops: 0};
    endtask

    task automatic model_edge(input bit s, input int d, input int l, input bit rt);
        bit   pending;
        bit   in_dly;
        exp_t cur;
        e_now++;
        pending = have && (e_now - 1 <= act_end);
        in_dly  = pending && (e_now - 1 < act_start);
        if (s) begin
            if (!pending) begin
                if (l != 0) begin
                    have      = 1'b1;
                    act_start = e_now + d;
                    act_end   = e_now + d + l - 1;
                end
            end else if (in_dly || !rt) begin
                drops = (drops == DMAX) ? DMAX : drops + 1;
            end else begin
                act_end = e_now + ((l == 0) ? 1 : l) - 1;
            end
        end
        cur.sig   = have && (e_now >= act_start) && (e_now <= act_end);
        cur.busy  = have && (e_now <= act_end);
        cur.done  = have && (e_now == act_end + 1);
        cur.drops = drops;
        exp_q.push_back(prev);
        prev = cur;
    endtask

    task automatic step(input bit s, input int d, input int l, input bit rt);
        @(negedge clk);
        strobe = s;
        delay  = CW'(d);
        length = CW'(l);
        retrig = rt;
        @(posedge clk);
        model_edge(s, d, l, rt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    endtask

    task automatic async_reset(input bit check);
        @(negedge clk);
        strobe = 1'b0;
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        if (check) begin
            chk("reset_signal",  int'(out_signal),  0);
            chk("reset_busy",    int'(out_busy),    0);
            chk("reset_done",    int'(out_done),    0);
            chk("reset_dropped", int'(out_dropped), 0);
        end
        exp_q.delete();
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en && (exp_q.size() > 0)) begin
                x = exp_q.pop_front();
                chk("signal",  int'(out_signal),  int'(x.sig));
                chk("busy",    int'(out_busy),    int'(x.busy));
                chk("done",    int'(out_done),    int'(x.done));
                chk("dropped", int'(out_dropped), x.drops);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        model_clear();
        #12;
        chk("por_signal",  int'(out_signal),  0);
        chk("por_busy",    int'(out_busy),    0);
        chk("por_dropped", int'(out_dropped), 0);
        async_reset(1'b1);

        step(1'b1, 0, 3, 1'b0);  idle(6);
        step(1'b1, 4, 2, 1'b0);  idle(10);

        step(1'b1, 5, 5, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, $urandom_range(0, 15), $urandom_range(1, 15), 1'b0);
        idle(12);

        step(1'b1, 0, 4, 1'b1);  idle(2);
        step(1'b1, 7, 4, 1'b1);  idle(10);

        step(1'b1, 3, 0, 1'b0);  idle(4);

        step(1'b1, 0, 3, 1'b0);  idle(3);
        step(1'b1, 0, 2, 1'b0);  idle(6);

        step(1'b1, 15, 15, 1'b0); idle(35);

        step(1'b1, 0, 10, 1'b0);
        step(1'b1, 2, 3, 1'b0);
        step(1'b1, 2, 3, 1'b0);
        idle(2);
        async_reset(1'b1);
        step(1'b1, 1, 2, 1'b0);  idle(8);

        for (int i = 0; i < 3000; i++) begin
            bit s;
            int d;
            int l;
            s = ($urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 5);
            l = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 6);
            step(s, d, l, 1'($urandom_range(0, 1)));
        end
        idle(40);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
